pwm_capture: RTL and testbench

- Receive-side counterpart of the PWM generator.
- Samples an external PWM line, measures high time and period in clk cycles, and recovers the 3-bit duty code the generator was programmed with.
- Flags a line that stops toggling.
- Sits on the input side of a board-level PWM loopback or servo/LED feedback path, in the same clock domain as the generator.

---
 rtl/pwm_capture.sv | 121 ++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period of pwm_in, recovers the duty code,
// and flags a line that stops rising. Optional glitch filter enabled by PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int unsigned CBITS       = 15,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CBITS:0]   high_cnt,
  output logic [CBITS:0]   period_cnt,
  output logic [2:0]       duty_code,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int unsigned CW = CBITS + 1;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [0:0] {WAIT_RISE, MEASURE} state_t;

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("pwm_capture: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  state_t                 state;
  logic [CW-1:0]          per_ctr;
  logic [CW-1:0]          hi_ctr;

  // Metastability synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
  localparam int unsigned FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [FW-1:0] filt_cnt;
  logic          f;

  // Level moves only after FILT_LEN consecutive samples disagreeing with it
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
      f        <= 1'b0;
    end else if (s == f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      f        <= s;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign lvl = f;
`else
  assign lvl = s;
`endif

  assign rise = lvl & ~lvl_d;

  // Measurement FSM; a rise always wins over the timeout in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_d       <= 1'b0;
      state       <= WAIT_RISE;
      per_ctr     <= '0;
      hi_ctr      <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_code   <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      lvl_d      <= lvl;
      meas_valid <= 1'b0;
      case (state)
        WAIT_RISE: begin
          if (rise) begin
            per_ctr     <= CW'(1);
            hi_ctr      <= CW'(1);
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            state       <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cnt <= per_ctr;
            high_cnt   <= hi_ctr;
            duty_code  <= hi_ctr[CBITS-2:CBITS-4];
            meas_valid <= 1'b1;
            per_ctr    <= CW'(1);
            hi_ctr     <= CW'(1);
          end else if (per_ctr == CMAX) begin
            stuck       <= 1'b1;
            stuck_level <= lvl;
            state       <= WAIT_RISE;
          end else begin
            per_ctr <= per_ctr + CW'(1);
            if (lvl && hi_ctr != CMAX) hi_ctr <= hi_ctr + CW'(1);
          end
        end
        default: state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized/directed bench for pwm_capture with a sample-stream reference model and scoreboard.
module tb_pwm_capture;

  localparam int CB   = 10;
  localparam int CW   = CB + 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PER  = 1 << CB;
  localparam int UNIT = 1 << (CB - 4);
  localparam int FL   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic [2:0]    duty_code;
  logic          meas_valid;
  logic          stuck;
  logic          stuck_level;

  pwm_capture #(.CBITS(CB), .SYNC_STAGES(2), .FILT_LEN(FL)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_code(duty_code),
    .meas_valid(meas_valid), .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct { int per; int hi; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the sampled line as a bit stream; each rise-to-rise window is a measurement
  bit m_prev = 1'b0;
  bit m_in_meas = 1'b0;
  bit m_win[$];
  bit m_stuck = 1'b0;
  bit m_stuck_lvl = 1'b0;
  bit m_raw[$];
  bit m_f = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_in_meas = 1'b0; m_win.delete(); m_stuck = 1'b0; m_stuck_lvl = 1'b0;
    m_raw.delete(); m_f = 1'b0;
  endtask

  task automatic model_step(input bit raw);
    bit b;
    int ones;
    exp_t e;
`ifdef PWM_CAP_FILTER_EN
    bit same;
    m_raw.push_back(raw);
    if (m_raw.size() > FL) void'(m_raw.pop_front());
    same = (m_raw.size() == FL);
    foreach (m_raw[i]) if (m_raw[i] != raw) same = 1'b0;
    if (same) m_f = raw;
    b = m_f;
`else
    b = raw;
`endif
    if (b && !m_prev) begin
      if (m_in_meas) begin
        ones = 0;
        foreach (m_win[i]) ones += int'(m_win[i]);
        e.per = m_win.size();
        e.hi  = ones;
        sb.push_back(e);
      end
      m_win.delete();
      m_win.push_back(1'b1);
      m_in_meas = 1'b1;
      m_stuck = 1'b0;
      m_stuck_lvl = 1'b0;
    end else if (m_in_meas) begin
      if (m_win.size() == CMAX) begin
        m_in_meas = 1'b0;
        m_stuck = 1'b1;
        m_stuck_lvl = b;
      end else begin
        m_win.push_back(b);
      end
    end
    m_prev = b;
  endtask

  task automatic tick(input bit v);
    pwm_in = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic pwm(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic do_reset(input bit v, input int n);
    chk("pending_before_reset", sb.size(), 0);
    pwm_in = v;
    rst = 1'b1;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
    model_reset();
    chk("rst_high_cnt", int'(high_cnt), 0);
    chk("rst_period_cnt", int'(period_cnt), 0);
    chk("rst_duty_code", int'(duty_code), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_stuck_level", int'(stuck_level), 0);
    rst = 1'b0;
  endtask

  task automatic check_stuck(input string name);
    chk({name, "_stuck"}, int'(stuck), int'(m_stuck));
    chk({name, "_stuck_level"}, int'(stuck_level), int'(m_stuck_lvl));
  endtask

  // Monitor: pops an expectation for every meas_valid pulse
  initial begin
    bit mv_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && meas_valid) begin
        chk("meas_valid_width", int'(mv_prev), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas_valid: got period %0d high %0d expected no pulse at %0t",
                   period_cnt, high_cnt, $time);
        end else begin
          e = sb.pop_front();
          chk("period_cnt", int'(period_cnt), e.per);
          chk("high_cnt", int'(high_cnt), e.hi);
          chk("duty_code", int'(duty_code), (e.hi >> (CB - 4)) & 7);
        end
      end
      mv_prev = rst ? 1'b0 : meas_valid;
    end
  end

  initial begin
    int lvl;
    do_reset(1'b0, 3);

    // Generator loopback at duty code 5, then sweep 1..7
    for (int i = 0; i < 4; i++) hold(1'b0, 0);
    pwm(5 * UNIT, PER - 5 * UNIT, 4);
    for (int sw = 1; sw <= 7; sw++) pwm(sw * UNIT, PER - sw * UNIT, 3);

    // Line stuck low, then recovery with a 100/300 PWM
    hold(1'b0, CMAX + 200);
    check_stuck("hold_low");
    chk("model_stuck_low", int'(m_stuck), 1);
    hold(1'b1, 50);
    check_stuck("after_first_rise");
    hold(1'b1, 50);
    hold(1'b0, 300);
    pwm(100, 300, 3);

    // Line stuck high
    hold(1'b1, CMAX + 200);
    check_stuck("hold_high");
    hold(1'b0, 300);
    pwm(100, 300, 2);

    // Reset mid-high of a 100/400 signal discards the partial measurement
    pwm(100, 300, 2);
    hold(1'b1, 50);
    do_reset(1'b1, 1);
    hold(1'b1, 50);
    hold(1'b0, 300);
    pwm(100, 300, 3);

    // Short low glitch inside the high pulse
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 49);
      hold(1'b0, 2);
      hold(1'b1, 49);
      hold(1'b0, 300);
    end

    // Random transitions, including single-cycle pulses
    lvl = 1;
    for (int i = 0; i < 300; i++) begin
      hold(1'(lvl), int'($urandom_range(1, 60)));
      lvl = 1 - lvl;
    end

    hold(1'b0, 20);
    check_stuck("final");
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
